// File: rtl/datapath_pkg.sv
// datapath_pkg: shared constants for the course-CPU datapath.
//   - bit positions of the one-hot control strobe vectors (ld, src, gsel, alu_op)
//   - instruction-register field positions
//   - CON condition codes and the helper that evaluates them
// Imported by cpu_datapath_if, datapath_alu and cpu_datapath.
package datapath_pkg;

  // ld strobes: {Rin,CONin,OUTin,LOin,HIin,MDRin,MARin,RZin,RYin,IRin,PCin}
  localparam int LD_W   = 11;
  localparam int LD_PC  = 0;
  localparam int LD_IR  = 1;
  localparam int LD_RY  = 2;
  localparam int LD_RZ  = 3;
  localparam int LD_MAR = 4;
  localparam int LD_MDR = 5;
  localparam int LD_HI  = 6;
  localparam int LD_LO  = 7;
  localparam int LD_OUT = 8;
  localparam int LD_CON = 9;
  localparam int LD_R   = 10;

  // src strobes: {Rout,Cout,PCout,RZout,LOout,HIout,MDRout,INout}
  localparam int SRC_W   = 8;
  localparam int SRC_IN  = 0;
  localparam int SRC_MDR = 1;
  localparam int SRC_HI  = 2;
  localparam int SRC_LO  = 3;
  localparam int SRC_RZ  = 4;
  localparam int SRC_PC  = 5;
  localparam int SRC_C   = 6;
  localparam int SRC_R   = 7;

  // gsel: {BAout,Grc,Grb,Gra}
  localparam int GSEL_W = 4;
  localparam int G_RA   = 0;
  localparam int G_RB   = 1;
  localparam int G_RC   = 2;
  localparam int G_BA   = 3;

  // alu_op: {IncPC,NOT,NEG,OR,AND,ROL,ROR,SHL,SHR,DIV,MUL,SUB,ADD}
  localparam int ALU_W     = 13;
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_MUL   = 2;
  localparam int ALU_DIV   = 3;
  localparam int ALU_SHR   = 4;
  localparam int ALU_SHL   = 5;
  localparam int ALU_ROR   = 6;
  localparam int ALU_ROL   = 7;
  localparam int ALU_AND   = 8;
  localparam int ALU_OR    = 9;
  localparam int ALU_NEG   = 10;
  localparam int ALU_NOT   = 11;
  localparam int ALU_INCPC = 12;

  // IR field positions (LSB of each register field, MSB of the constant)
  localparam int IR_RA_LSB   = 23;
  localparam int IR_RB_LSB   = 19;
  localparam int IR_RC_LSB   = 15;
  localparam int IR_C_MSB    = 18;
  localparam int IR_COND_LSB = 19;

  typedef enum logic [1:0] {
    COND_ZERO    = 2'b00,
    COND_NONZERO = 2'b01,
    COND_POS     = 2'b10,
    COND_NEG     = 2'b11
  } cond_e;

  // Evaluates a branch condition from the zero and sign flags of a value,
  // which keeps the test independent of the bus width.
  function automatic logic cond_met(input cond_e c, input logic is_zero, input logic is_neg);
    case (c)
      COND_ZERO:    cond_met = is_zero;
      COND_NONZERO: cond_met = !is_zero;
      COND_POS:     cond_met = !is_zero && !is_neg;
      default:      cond_met = is_neg;
    endcase
  endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: control bundle from the control unit into the datapath.
//   ld      load enables (one bit per destination register)
//   src     bus driver selects
//   gsel    register-field select {BAout,Grc,Grb,Gra}
//   mem_rd  MDR input takes RAM[MAR] instead of the bus
//   mem_wr  RAM[MAR] <= MDR at the clock edge
//   alu_op  one-hot ALU operation
//   in_port external input unit value
// Modports: master = control unit / bench, slave = datapath.
// There is no valid/ready handshake here: every strobe is a level that the
// datapath samples on each rising clock edge; sequencing is owned entirely by
// the control unit, which must hold a strobe for exactly the cycles it wants.
interface cpu_datapath_if import datapath_pkg::*; #(
  parameter int BITS = 32
);
  logic [LD_W-1:0]   ld;
  logic [SRC_W-1:0]  src;
  logic [GSEL_W-1:0] gsel;
  logic              mem_rd;
  logic              mem_wr;
  logic [ALU_W-1:0]  alu_op;
  logic [BITS-1:0]   in_port;

  modport master (output ld, src, gsel, mem_rd, mem_wr, alu_op, in_port);
  modport slave  (input  ld, src, gsel, mem_rd, mem_wr, alu_op, in_port);
endinterface

// File: rtl/datapath_alu.sv
// datapath_alu: combinational ALU of the course-CPU datapath.
//   a      operand A (RY)
//   b      operand B (bus)
//   op     one-hot operation; the lowest set bit wins, none set passes b
//   result 64-bit result; only MUL and DIV fill the upper half
// Optional macro DATAPATH_DIV_EN: when defined a signed divider is built
// (RZ[31:0]=quotient, RZ[63:32]=remainder, divide by zero gives {A, ones});
// when undefined no divider exists and DIV yields 0.
module datapath_alu import datapath_pkg::*; #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  input  logic [ALU_W-1:0]  op,
  output logic [2*BITS-1:0] result
);
  localparam int SHW = $clog2(BITS);

  logic [SHW-1:0]    sh;
  logic [2*BITS-1:0] dbl_r;
  logic [2*BITS-1:0] dbl_l;
  logic [2*BITS-1:0] prod;
  logic [2*BITS-1:0] div_res;
  logic [2*BITS-1:0] full;
  logic [BITS-1:0]   low;
  logic              use_full;

  assign sh = b[SHW-1:0];

  // Rotates come from shifting a doubled copy of A: the low half of the
  // right shift is ROR, the high half of the left shift is ROL.
  assign dbl_r = {a, a} >> sh;
  assign dbl_l = {a, a} << sh;

  // Operands sign-extended to full width so the product is a true signed 64-bit result.
  assign prod = $signed({{BITS{a[BITS-1]}}, a}) * $signed({{BITS{b[BITS-1]}}, b});

`ifdef DATAPATH_DIV_EN
  logic [BITS-1:0] divisor;
  logic [BITS-1:0] quot;
  logic [BITS-1:0] rem;

  // Divisor forced to 1 on zero so the divider never sees 0; the result is
  // replaced below anyway.
  assign divisor = (b == '0) ? {{(BITS-1){1'b0}}, 1'b1} : b;
  assign quot    = $signed(a) / $signed(divisor);
  assign rem     = $signed(a) % $signed(divisor);
  assign div_res = (b == '0) ? {a, {BITS{1'b1}}} : {rem, quot};
`else
  assign div_res = '0;
`endif

  always_comb begin
    low      = b;
    full     = '0;
    use_full = 1'b0;
    if (op[ALU_ADD])        low = a + b;
    else if (op[ALU_SUB])   low = a - b;
    else if (op[ALU_MUL])   begin full = prod;    use_full = 1'b1; end
    else if (op[ALU_DIV])   begin full = div_res; use_full = 1'b1; end
    else if (op[ALU_SHR])   low = a >> sh;
    else if (op[ALU_SHL])   low = a << sh;
    else if (op[ALU_ROR])   low = dbl_r[BITS-1:0];
    else if (op[ALU_ROL])   low = dbl_l[2*BITS-1:BITS];
    else if (op[ALU_AND])   low = a & b;
    else if (op[ALU_OR])    low = a | b;
    else if (op[ALU_NEG])   low = '0 - b;
    else if (op[ALU_NOT])   low = ~b;
    else if (op[ALU_INCPC]) low = b + {{(BITS-1){1'b0}}, 1'b1};
    result = use_full ? full : {{BITS{1'b0}}, low};
  end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus datapath of the course CPU.
//   clk       rising-edge clock
//   reset     asynchronous, active-low; clears every register (not the RAM)
//   ctl       control strobes from the control unit (cpu_datapath_if.slave)
//   out_port  OUT register
//   bus       current bus value
//   pc, ir, mar, mdr, hi, lo, c_sext   register / debug views
//   rz        64-bit RZ register
//   regs      R0..R(REGISTERS-1) packed, R0 in the lowest BITS
//   con       CON flip-flop
// Optional macro DATAPATH_DIV_EN enables the signed divider in datapath_alu;
// without it DIV writes RZ = 0.
module cpu_datapath import datapath_pkg::*; #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16,
  parameter int RAMSIZE   = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  cpu_datapath_if.slave             ctl,
  output logic [BITS-1:0]           out_port,
  output logic [BITS-1:0]           bus,
  output logic [BITS-1:0]           pc,
  output logic [BITS-1:0]           ir,
  output logic [BITS-1:0]           mar,
  output logic [BITS-1:0]           mdr,
  output logic [BITS-1:0]           hi,
  output logic [BITS-1:0]           lo,
  output logic [BITS-1:0]           c_sext,
  output logic [2*BITS-1:0]         rz,
  output logic [REGISTERS*BITS-1:0] regs,
  output logic                      con
);
  localparam int AW     = $clog2(RAMSIZE);
  localparam int RIDX_W = $clog2(REGISTERS);

  logic [BITS-1:0]   ry;
  logic [BITS-1:0]   gpr [REGISTERS];
  logic [BITS-1:0]   ram [RAMSIZE];
  logic [RIDX_W-1:0] sel_idx;
  logic              sel_any;
  logic [BITS-1:0]   gpr_out;
  logic [AW-1:0]     ram_addr;
  logic [BITS-1:0]   ram_rd;
  logic [2*BITS-1:0] alu_result;
  logic              cond_now;

  assign c_sext = {{(BITS-IR_C_MSB-1){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};

  // Select/encode: Gra beats Grb beats Grc; with no G bit the index is 0 and
  // Rin is suppressed.
  always_comb begin
    sel_idx = '0;
    if (ctl.gsel[G_RA])      sel_idx = ir[IR_RA_LSB +: RIDX_W];
    else if (ctl.gsel[G_RB]) sel_idx = ir[IR_RB_LSB +: RIDX_W];
    else if (ctl.gsel[G_RC]) sel_idx = ir[IR_RC_LSB +: RIDX_W];
  end

  assign sel_any = |ctl.gsel[G_RC:G_RA];

  // BAout turns R0 into a constant zero for base-address arithmetic.
  assign gpr_out = (ctl.gsel[G_BA] && sel_idx == '0) ? '0 : gpr[sel_idx];

  always_comb begin
    bus = '0;
    if (ctl.src[SRC_R])        bus = gpr_out;
    else if (ctl.src[SRC_C])   bus = c_sext;
    else if (ctl.src[SRC_PC])  bus = pc;
    else if (ctl.src[SRC_RZ])  bus = rz[BITS-1:0];
    else if (ctl.src[SRC_LO])  bus = lo;
    else if (ctl.src[SRC_HI])  bus = hi;
    else if (ctl.src[SRC_MDR]) bus = mdr;
    else if (ctl.src[SRC_IN])  bus = ctl.in_port;
  end

  assign cond_now = cond_met(cond_e'(ir[IR_COND_LSB +: 2]), bus == '0, bus[BITS-1]);

  datapath_alu #(.BITS(BITS)) u_alu (
    .a      (ry),
    .b      (bus),
    .op     (ctl.alu_op),
    .result (alu_result)
  );

  // RAM: the low address bits of MAR give the modulo-RAMSIZE wrap. The read
  // is combinational and only becomes visible through MDR, so a read and a
  // write in the same cycle hand MDR the old word.
  assign ram_addr = mar[AW-1:0];
  assign ram_rd   = ram[ram_addr];

  always_ff @(posedge clk) begin
    if (ctl.mem_wr) ram[ram_addr] <= mdr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      ir       <= '0;
      ry       <= '0;
      rz       <= '0;
      mar      <= '0;
      mdr      <= '0;
      hi       <= '0;
      lo       <= '0;
      out_port <= '0;
      con      <= 1'b0;
      for (int i = 0; i < REGISTERS; i++) gpr[i] <= '0;
    end else begin
      if (ctl.ld[LD_PC])  pc       <= bus;
      if (ctl.ld[LD_IR])  ir       <= bus;
      if (ctl.ld[LD_RY])  ry       <= bus;
      if (ctl.ld[LD_RZ])  rz       <= alu_result;
      if (ctl.ld[LD_MAR]) mar      <= bus;
      if (ctl.ld[LD_MDR]) mdr      <= ctl.mem_rd ? ram_rd : bus;
      if (ctl.ld[LD_HI])  hi       <= rz[2*BITS-1:BITS];
      if (ctl.ld[LD_LO])  lo       <= rz[BITS-1:0];
      if (ctl.ld[LD_OUT]) out_port <= bus;
      if (ctl.ld[LD_CON]) con      <= cond_now;
      if (ctl.ld[LD_R] && sel_any) gpr[sel_idx] <= bus;
    end
  end

  for (genvar i = 0; i < REGISTERS; i++) begin : g_regs
    assign regs[i*BITS +: BITS] = gpr[i];
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed bench for cpu_datapath. Expected values are
// pushed onto a scoreboard queue when a step is driven and popped when the
// resulting DUT output is sampled (#1 after the edge, or mid-low-phase for
// combinational bus values).
module tb_cpu_datapath;
  import datapath_pkg::*;

  localparam int BITS      = 32;
  localparam int REGISTERS = 16;
  localparam int RAMSIZE   = 512;

  localparam logic [10:0] L_PC  = 11'd1 << LD_PC;
  localparam logic [10:0] L_IR  = 11'd1 << LD_IR;
  localparam logic [10:0] L_RY  = 11'd1 << LD_RY;
  localparam logic [10:0] L_RZ  = 11'd1 << LD_RZ;
  localparam logic [10:0] L_MAR = 11'd1 << LD_MAR;
  localparam logic [10:0] L_MDR = 11'd1 << LD_MDR;
  localparam logic [10:0] L_HI  = 11'd1 << LD_HI;
  localparam logic [10:0] L_LO  = 11'd1 << LD_LO;
  localparam logic [10:0] L_OUT = 11'd1 << LD_OUT;
  localparam logic [10:0] L_CON = 11'd1 << LD_CON;
  localparam logic [10:0] L_R   = 11'd1 << LD_R;

  localparam logic [7:0] S_IN  = 8'd1 << SRC_IN;
  localparam logic [7:0] S_MDR = 8'd1 << SRC_MDR;
  localparam logic [7:0] S_RZ  = 8'd1 << SRC_RZ;
  localparam logic [7:0] S_PC  = 8'd1 << SRC_PC;
  localparam logic [7:0] S_C   = 8'd1 << SRC_C;
  localparam logic [7:0] S_R   = 8'd1 << SRC_R;

  localparam logic [3:0] GA  = 4'd1 << G_RA;
  localparam logic [3:0] GB  = 4'd1 << G_RB;
  localparam logic [3:0] GC  = 4'd1 << G_RC;
  localparam logic [3:0] GBA = 4'd1 << G_BA;

  localparam logic [12:0] OP_MUL = 13'd1 << ALU_MUL;
  localparam logic [12:0] OP_INC = 13'd1 << ALU_INCPC;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_datapath_if #(.BITS(BITS)) ctl ();

  logic [BITS-1:0]           out_port, bus, pc, ir, mar, mdr, hi, lo, c_sext;
  logic [2*BITS-1:0]         rz;
  logic [REGISTERS*BITS-1:0] regs;
  logic                      con;

  cpu_datapath #(.BITS(BITS), .REGISTERS(REGISTERS), .RAMSIZE(RAMSIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .ctl      (ctl),
    .out_port (out_port),
    .bus      (bus),
    .pc       (pc),
    .ir       (ir),
    .mar      (mar),
    .mdr      (mdr),
    .hi       (hi),
    .lo       (lo),
    .c_sext   (c_sext),
    .rz       (rz),
    .regs     (regs),
    .con      (con)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  function automatic logic [BITS-1:0] reg_at(input int n);
    return regs[n*BITS +: BITS];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    ctl.ld      = '0;
    ctl.src     = '0;
    ctl.gsel    = '0;
    ctl.mem_rd  = 1'b0;
    ctl.mem_wr  = 1'b0;
    ctl.alu_op  = '0;
    ctl.in_port = '0;
  endtask

  // Applies one cycle's strobes in the low phase; bus is stable #1 later.
  task automatic drive(input logic [10:0] l, input logic [7:0] s,
                       input logic [3:0] g = 4'd0, input logic [12:0] op = 13'd0,
                       input logic [31:0] inp = 32'd0, input logic rd = 1'b0,
                       input logic wr = 1'b0);
    @(negedge clk);
    ctl.ld      = l;
    ctl.src     = s;
    ctl.gsel    = g;
    ctl.alu_op  = op;
    ctl.in_port = inp;
    ctl.mem_rd  = rd;
    ctl.mem_wr  = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  // ---------------- ALU table (RY = 0xFFFF_FFFE throughout) ----------------
  logic [12:0] t_op  [15];
  logic [31:0] t_b   [15];
  logic [63:0] t_exp [15];

  initial begin
    t_op[0]  = 13'd1 << ALU_ADD;   t_b[0]  = 32'd3;          t_exp[0]  = 64'h0000_0000_0000_0001;
    t_op[1]  = 13'd1 << ALU_SUB;   t_b[1]  = 32'd3;          t_exp[1]  = 64'h0000_0000_FFFF_FFFB;
    t_op[2]  = 13'd1 << ALU_SHR;   t_b[2]  = 32'd4;          t_exp[2]  = 64'h0000_0000_0FFF_FFFF;
    t_op[3]  = 13'd1 << ALU_SHL;   t_b[3]  = 32'd4;          t_exp[3]  = 64'h0000_0000_FFFF_FFE0;
    t_op[4]  = 13'd1 << ALU_ROR;   t_b[4]  = 32'h24;         t_exp[4]  = 64'h0000_0000_EFFF_FFFF;
    t_op[5]  = 13'd1 << ALU_ROL;   t_b[5]  = 32'd4;          t_exp[5]  = 64'h0000_0000_FFFF_FFEF;
    t_op[6]  = 13'd1 << ALU_AND;   t_b[6]  = 32'h0F0F_0F0F;  t_exp[6]  = 64'h0000_0000_0F0F_0F0E;
    t_op[7]  = 13'd1 << ALU_OR;    t_b[7]  = 32'd1;          t_exp[7]  = 64'h0000_0000_FFFF_FFFF;
    t_op[8]  = 13'd1 << ALU_NEG;   t_b[8]  = 32'd5;          t_exp[8]  = 64'h0000_0000_FFFF_FFFB;
    t_op[9]  = 13'd1 << ALU_NOT;   t_b[9]  = 32'h0000_FFFF;  t_exp[9]  = 64'h0000_0000_FFFF_0000;
    t_op[10] = 13'd1 << ALU_INCPC; t_b[10] = 32'hFFFF_FFFF;  t_exp[10] = 64'h0000_0000_0000_0000;
    t_op[11] = 13'd0;              t_b[11] = 32'h1234_5678;  t_exp[11] = 64'h0000_0000_1234_5678;
    t_op[12] = 13'b11;             t_b[12] = 32'd3;          t_exp[12] = 64'h0000_0000_0000_0001;
`ifdef DATAPATH_DIV_EN
    t_op[13] = 13'd1 << ALU_DIV;   t_b[13] = 32'd3;          t_exp[13] = 64'hFFFF_FFFE_0000_0000;
    t_op[14] = 13'd1 << ALU_DIV;   t_b[14] = 32'd0;          t_exp[14] = 64'hFFFF_FFFE_FFFF_FFFF;
`else
    t_op[13] = 13'd1 << ALU_DIV;   t_b[13] = 32'd3;          t_exp[13] = 64'h0;
    t_op[14] = 13'd1 << ALU_DIV;   t_b[14] = 32'd0;          t_exp[14] = 64'h0;
`endif
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_val("rst_pc", 0);   check(pc);
    expect_val("rst_rz", 0);   check(rz);
    expect_val("rst_con", 0);  check(con);
    @(negedge clk);
    reset = 1'b1;

    // Preload RAM[0] with the fetch word through MDR.
    drive(L_MDR, S_IN, 4'd0, 13'd0, 32'h0880_0005);
    expect_val("pre_mdr", 32'h0880_0005); tick(); check(mdr);
    drive(11'd0, 8'd0, 4'd0, 13'd0, 32'd0, 1'b0, 1'b1); tick();

    // Fetch.
    drive(L_MAR | L_RZ, S_PC, 4'd0, OP_INC);
    expect_val("f0_rz", 1); expect_val("f0_mar", 0);
    tick(); check(rz); check(mar);
    drive(L_PC | L_MDR, S_RZ, 4'd0, 13'd0, 32'd0, 1'b1);
    expect_val("f1_pc", 1); expect_val("f1_mdr", 32'h0880_0005);
    tick(); check(pc); check(mdr);
    drive(L_IR, S_MDR);
    expect_val("f2_ir", 32'h0880_0005); expect_val("f2_csext", 5);
    tick(); check(ir); check(c_sext);

    // Load immediate into Ra=1.
    drive(L_R, S_C, GA);
    expect_val("ldi_bus", 5); check(bus);
    expect_val("ldi_r1", 5); tick(); check(reg_at(1));

    // R0 = 7, then BAout masks it.
    drive(L_IR, S_IN, 4'd0, 13'd0, 32'h0); tick();
    drive(L_R, S_IN, GA, 13'd0, 32'd7);
    expect_val("r0_load", 7); tick(); check(reg_at(0));
    drive(11'd0, S_R, GA);
    expect_val("rout_r0", 7); check(bus); tick();
    drive(11'd0, S_R, GA | GBA);
    expect_val("baout_r0", 0); check(bus); tick();

    // MUL -2 * 3, then HI/LO.
    drive(L_RY, S_IN, 4'd0, 13'd0, 32'hFFFF_FFFE); tick();
    drive(L_RZ, S_IN, 4'd0, OP_MUL, 32'd3);
    expect_val("mul_rz", 64'hFFFF_FFFF_FFFF_FFFA); tick(); check(rz);
    drive(L_HI | L_LO, 8'd0);
    expect_val("mul_hi", 32'hFFFF_FFFF); expect_val("mul_lo", 32'hFFFF_FFFA);
    tick(); check(hi); check(lo);

    // ALU table.
    for (int i = 0; i < 15; i++) begin
      drive(L_RZ, S_IN, 4'd0, t_op[i], t_b[i]);
      expect_val($sformatf("alu_%0d", i), t_exp[i]);
      tick(); check(rz);
    end

    // CON: 01 nonzero, 11 negative, 10 positive, 00 zero.
    drive(L_IR, S_IN, 4'd0, 13'd0, 32'h0008_0000); tick();
    drive(L_CON, S_IN, 4'd0, 13'd0, 32'd0);
    expect_val("con_nz_0", 0); tick(); check(con);
    drive(L_CON, S_IN, 4'd0, 13'd0, 32'd4);
    expect_val("con_nz_4", 1); tick(); check(con);
    drive(11'd0, S_IN, 4'd0, 13'd0, 32'd0);
    expect_val("con_hold", 1); tick(); check(con);
    drive(L_IR, S_IN, 4'd0, 13'd0, 32'h0018_0000); tick();
    drive(L_CON, S_IN, 4'd0, 13'd0, 32'd1);
    expect_val("con_neg_1", 0); tick(); check(con);
    drive(L_CON, S_IN, 4'd0, 13'd0, 32'h8000_0000);
    expect_val("con_neg_min", 1); tick(); check(con);
    drive(L_IR, S_IN, 4'd0, 13'd0, 32'h0010_0000); tick();
    drive(L_CON, S_IN, 4'd0, 13'd0, 32'h8000_0000);
    expect_val("con_pos_min", 0); tick(); check(con);
    drive(L_CON, S_IN, 4'd0, 13'd0, 32'd7);
    expect_val("con_pos_7", 1); tick(); check(con);
    drive(L_IR, S_IN, 4'd0, 13'd0, 32'h0); tick();
    drive(L_CON, S_IN, 4'd0, 13'd0, 32'd0);
    expect_val("con_z_0", 1); tick(); check(con);
    drive(L_CON, S_IN, 4'd0, 13'd0, 32'd9);
    expect_val("con_z_9", 0); tick(); check(con);

    // Jump-and-link: Ra=2 holds 20, Rb=3 receives return address.
    drive(L_IR, S_IN, 4'd0, 13'd0, 32'h0118_0000); tick();
    drive(L_R, S_IN, GA, 13'd0, 32'd20);
    expect_val("jal_r2", 20); tick(); check(reg_at(2));
    drive(L_PC, S_IN, 4'd0, 13'd0, 32'd10);
    expect_val("jal_pc10", 10); tick(); check(pc);
    drive(L_RZ, S_PC, 4'd0, OP_INC);
    expect_val("jal_rz", 11); tick(); check(rz);
    drive(L_R, S_RZ, GB);
    expect_val("jal_rb", 11); tick(); check(reg_at(3));
    drive(L_PC, S_R, GA);
    expect_val("jal_pc20", 20); tick(); check(pc);

    drive(11'd0, S_R, GA | GB);
    expect_val("gsel_prio", 20); check(bus); tick();
    drive(L_PC | L_R, S_IN, GC, 13'd0, 32'h55);
    expect_val("dual_pc", 32'h55); expect_val("dual_r0", 32'h55);
    tick(); check(pc); check(reg_at(0));
    drive(11'd0, S_PC | S_MDR);
    expect_val("bus_prio_pc", 32'h55); check(bus); tick();
    drive(11'd0, S_R | S_C, GA);
    expect_val("bus_prio_r", 20); check(bus); tick();
    drive(L_OUT, S_PC);
    expect_val("out_port", 32'h55); tick(); check(out_port);
    drive(L_R, S_IN, 4'd0, 13'd0, 32'hDEAD);
    expect_val("rin_nog", 32'h55); tick(); check(reg_at(0));

    // RAM wrap and read/write in one cycle.
    drive(L_MAR, S_IN, 4'd0, 13'd0, 32'd512); tick();
    drive(L_MDR, 8'd0, 4'd0, 13'd0, 32'd0, 1'b1);
    expect_val("ram_wrap", 32'h0880_0005); tick(); check(mdr);
    drive(L_MAR, S_IN, 4'd0, 13'd0, 32'd1); tick();
    drive(L_MDR, S_IN, 4'd0, 13'd0, 32'hAAAA); tick();
    drive(11'd0, 8'd0, 4'd0, 13'd0, 32'd0, 1'b0, 1'b1); tick();
    drive(L_MDR, S_IN, 4'd0, 13'd0, 32'hBBBB); tick();
    drive(L_MDR, 8'd0, 4'd0, 13'd0, 32'd0, 1'b1, 1'b1);
    expect_val("rdwr_old", 32'hAAAA); tick(); check(mdr);
    drive(L_MDR, 8'd0, 4'd0, 13'd0, 32'd0, 1'b1);
    expect_val("rdwr_new", 32'hBBBB); tick(); check(mdr);

    // Mid-run asynchronous reset, away from any clock edge.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    expect_val("mid_pc", 0);   check(pc);
    expect_val("mid_ir", 0);   check(ir);
    expect_val("mid_rz", 0);   check(rz);
    expect_val("mid_out", 0);  check(out_port);
    expect_val("mid_con", 0);  check(con);
    expect_val("mid_regs", 1); check(regs == '0);
    @(negedge clk);
    reset = 1'b1;
    drive(L_MDR, 8'd0, 4'd0, 13'd0, 32'd0, 1'b1);
    expect_val("ram_kept", 32'h0880_0005); tick(); check(mdr);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
